mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one backing memory port between instruction fetch (read-only) and the memory-access stage (load/store) of the 32-bit MIPS pipeline.
- Serialises requests one at a time and drives the variable-latency memory handshake.
- Returns read data and a one-cycle done pulse to the winning requester, and raises stall flags toward the pipeline.
- Data side has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits before fetch is forced to win (>=1)

Ports:
clk  in  1  clock, all logic on posedge
rst  in  1  synchronous, active-high reset
i_req  in  1  fetch request; held with i_addr until i_done
i_addr  in  ADDR_W  fetch address
i_rdata  out  DATA_W  fetch read data, valid while i_done=1
i_done  out  1  one-cycle completion pulse to fetch
d_req  in  1  mem-stage request; held with d_we/d_addr/d_wdata until d_done
d_we  in  1  1=store (SW), 0=load (LW)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_rdata  out  DATA_W  load data, valid while d_done=1
d_done  out  1  one-cycle completion pulse to mem stage
m_req  out  1  memory request valid
m_we  out  1  memory write enable
m_addr  out  ADDR_W  memory address
m_wdata  out  DATA_W  memory write data
m_ready  in  1  memory accepts request this cycle (m_req & m_ready = handshake)
m_rvalid  in  1  memory response: read data valid, or write acknowledge
m_rdata  in  DATA_W  memory read data
stall_if  out  1  i_req & ~i_done (combinational)
stall_mem  out  1  d_req & ~d_done (combinational)

Behaviour:
- Reset: FSM=IDLE; m_req, m_we, i_done, d_done = 0; m_addr, m_wdata, i_rdata, d_rdata = 0; owner=DATA; starve_cnt=0. Reset mid-transaction abandons it; no done pulse is produced for it, and a late m_rvalid arriving in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT.
- IDLE transitions:
  - Eligible requester = req high and its done not high this cycle, which blocks re-grant during the turnaround cycle.
  - If any requester is eligible: choose winner, latch owner, and register m_addr/m_we/m_wdata from the winner's inputs (fetch: m_we=0, m_wdata unchanged). Set m_req=1 and go to ISSUE.
- ISSUE: hold m_req and payload stable. On m_ready, drop m_req the next cycle and go to WAIT. If m_rvalid arrives in the same cycle as m_ready, complete immediately as in WAIT.
- WAIT: on m_rvalid, register m_rdata into the owner's rdata (loads and fetches only; stores leave d_rdata unchanged), pulse the owner's done for exactly one cycle, and go to IDLE.
- Minimum latency, req to done: 3 cycles with m_ready=1 and m_rvalid one cycle after acceptance. Back-to-back throughput: one transaction per 4 cycles.
- Priority:
  - Data wins when starve_cnt < STARVE_LIMIT; otherwise fetch wins.
  - starve_cnt increments, saturating at STARVE_LIMIT, on each data grant made while i_req is high.
  - starve_cnt clears to 0 on every fetch grant.
  - Width is $clog2(STARVE_LIMIT+1).
- Simultaneous i_req and d_req: resolved by the priority rule above. Only the single request is present: it is granted regardless of starve_cnt.
- Requester contract: must deassert req, or present a new request, in the cycle its done is high. The arbiter ignores it for that cycle only.
- The done pulses are mutually exclusive; never both in one cycle.

Optional Feature:
- Macro ARB_PERF_CNT_EN, when defined, adds three output ports (32-bit, wrap-around, cleared by rst):
  - perf_i_grants: count of fetch grants.
  - perf_d_grants: count of data grants.
  - perf_starve_forced: count of fetch grants won because starve_cnt reached STARVE_LIMIT while d_req was high.
- When the macro is undefined, these ports and counters are absent, with no other behavioural change.

Test Plan:
- Single load: d_req=1, d_we=0, d_addr=0x100, m_ready=1, m_rvalid with m_rdata=0xDEADBEEF one cycle after accept -> m_addr=0x100, m_we=0; d_done pulses once with d_rdata=0xDEADBEEF; stall_mem high until then.
- Store: d_we=1, d_addr=0x200, d_wdata=0x12345678 -> m_we=1, m_wdata=0x12345678; d_done on write ack; d_rdata unchanged.
- Contention: i_req and d_req both held, STARVE_LIMIT=4, memory responds instantly -> grant order D,D,D,D,I,D...; starve_cnt returns to 0 after the fetch grant.
- Backpressure: m_ready held 0 for 5 cycles -> m_req stays 1 with a stable payload; no done; accepted on cycle 6.
- Reset in WAIT: assert rst for 1 cycle before m_rvalid, then m_rvalid=1 -> no done pulse, all outputs 0, FSM in IDLE.
- With ARB_PERF_CNT_EN: the contention scenario run for 10 grants -> perf_d_grants=8, perf_i_grants=2, perf_starve_forced=2.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Shared fetch / mem-stage / backing-memory signal bundle for mem_port_arbiter.
// slave = arbiter view, master = pipeline-plus-memory view.
interface mem_port_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic [DATA_W-1:0] i_rdata;
   logic              i_done;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic [DATA_W-1:0] d_rdata;
   logic              d_done;
   logic              m_req;
   logic              m_we;
   logic [ADDR_W-1:0] m_addr;
   logic [DATA_W-1:0] m_wdata;
   logic              m_ready;
   logic              m_rvalid;
   logic [DATA_W-1:0] m_rdata;
   logic              stall_if;
   logic              stall_mem;

   modport slave (
      input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rvalid, m_rdata,
      output i_rdata, i_done, d_rdata, d_done, m_req, m_we, m_addr, m_wdata,
             stall_if, stall_mem
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_addr, d_wdata, m_ready, m_rvalid, m_rdata,
      input  i_rdata, i_done, d_rdata, d_done, m_req, m_we, m_addr, m_wdata,
             stall_if, stall_mem
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates fetch and mem-stage onto one memory port; data-first with a fetch starvation guard.
// Optional grant counters when ARB_PERF_CNT_EN is defined.
module mem_port_arbiter #(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   mem_port_arbiter_if.slave    bus
`ifdef ARB_PERF_CNT_EN
   ,
   output logic [31:0]          perf_i_grants,
   output logic [31:0]          perf_d_grants,
   output logic [31:0]          perf_starve_forced
`endif
);
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

   state_t            state;
   logic              owner_d;
   logic [CNT_W-1:0]  starve_cnt;
   logic              m_req_q;
   logic              m_we_q;
   logic [ADDR_W-1:0] m_addr_q;
   logic [DATA_W-1:0] m_wdata_q;
   logic [DATA_W-1:0] i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;
   logic              i_done_q;
   logic              d_done_q;

   logic i_elig, d_elig, turnaround, starved, grant_d, grant_i, complete;

   assign i_elig     = bus.i_req & ~i_done_q;
   assign d_elig     = bus.d_req & ~d_done_q;
   // The done cycle is a dead cycle for both sides, so a held competing
   // request cannot slip in while the finishing requester turns around.
   assign turnaround = i_done_q | d_done_q;
   assign starved    = (starve_cnt >= LIMIT);
   assign grant_d    = (state == IDLE) & ~turnaround & d_elig & (~i_elig | ~starved);
   assign grant_i    = (state == IDLE) & ~turnaround & i_elig & (~d_elig | starved);
   assign complete   = bus.m_rvalid & ((state == WAIT) | ((state == ISSUE) & bus.m_ready));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         owner_d    <= 1'b1;
         starve_cnt <= '0;
         m_req_q    <= 1'b0;
         m_we_q     <= 1'b0;
         m_addr_q   <= '0;
         m_wdata_q  <= '0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
         i_done_q   <= 1'b0;
         d_done_q   <= 1'b0;
      end else begin
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (grant_d) begin
                  owner_d   <= 1'b1;
                  m_req_q   <= 1'b1;
                  m_we_q    <= bus.d_we;
                  m_addr_q  <= bus.d_addr;
                  m_wdata_q <= bus.d_wdata;
                  state     <= ISSUE;
                  if (bus.i_req && !starved)
                     starve_cnt <= starve_cnt + CNT_W'(1);
               end else if (grant_i) begin
                  owner_d    <= 1'b0;
                  m_req_q    <= 1'b1;
                  m_we_q     <= 1'b0;
                  m_addr_q   <= bus.i_addr;
                  starve_cnt <= '0;
                  state      <= ISSUE;
               end
            end
            ISSUE: begin
               if (bus.m_ready) begin
                  m_req_q <= 1'b0;
                  state   <= complete ? IDLE : WAIT;
               end
            end
            WAIT: begin
               if (bus.m_rvalid)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase

         if (complete) begin
            if (owner_d) begin
               d_done_q <= 1'b1;
               if (!m_we_q)
                  d_rdata_q <= bus.m_rdata;
            end else begin
               i_done_q  <= 1'b1;
               i_rdata_q <= bus.m_rdata;
            end
         end
      end
   end

`ifdef ARB_PERF_CNT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_i_grants      <= '0;
         perf_d_grants      <= '0;
         perf_starve_forced <= '0;
      end else begin
         if (grant_i)
            perf_i_grants <= perf_i_grants + 32'd1;
         if (grant_d)
            perf_d_grants <= perf_d_grants + 32'd1;
         if (grant_i && d_elig && starved)
            perf_starve_forced <= perf_starve_forced + 32'd1;
      end
   end
`endif

   assign bus.m_req     = m_req_q;
   assign bus.m_we      = m_we_q;
   assign bus.m_addr    = m_addr_q;
   assign bus.m_wdata   = m_wdata_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.d_rdata   = d_rdata_q;
   assign bus.i_done    = i_done_q;
   assign bus.d_done    = d_done_q;
   assign bus.stall_if  = bus.i_req & ~i_done_q;
   assign bus.stall_mem = bus.d_req & ~d_done_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter (STARVE_LIMIT=4).
// Perf counter checks are compiled in only with ARB_PERF_CNT_EN.
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef ARB_PERF_CNT_EN
   logic [31:0] perf_i_grants, perf_d_grants, perf_starve_forced;
`endif

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
`ifdef ARB_PERF_CNT_EN
      ,
      .perf_i_grants      (perf_i_grants),
      .perf_d_grants      (perf_d_grants),
      .perf_starve_forced (perf_starve_forced)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      bus.i_req = 0; bus.i_addr = '0; bus.d_req = 0; bus.d_we = 0;
      bus.d_addr = '0; bus.d_wdata = '0; bus.m_ready = 0; bus.m_rvalid = 0; bus.m_rdata = '0;
      rst = 1;
      tick(); tick();
      checks++;
      if ({bus.m_req, bus.m_we, bus.i_done, bus.d_done} !== 4'b0000) begin
         errors++; $display("FAIL reset_ctrl: got %b expected 0000", {bus.m_req, bus.m_we, bus.i_done, bus.d_done});
      end
      checks++;
      if (bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0) begin
         errors++; $display("FAIL reset_payload: got addr=%h wdata=%h expected 0", bus.m_addr, bus.m_wdata);
      end
      checks++;
      if (bus.i_rdata !== 32'h0 || bus.d_rdata !== 32'h0) begin
         errors++; $display("FAIL reset_rdata: got i=%h d=%h expected 0", bus.i_rdata, bus.d_rdata);
      end
      checks++;
      if (dut.starve_cnt !== 3'd0) begin
         errors++; $display("FAIL reset_starve: got %0d expected 0", dut.starve_cnt);
      end
      rst = 0;
      tick();
   endtask

   task automatic test_load();
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h100; bus.m_ready = 1; bus.m_rvalid = 0;
      #1;
      checks++;
      if (bus.stall_mem !== 1'b1) begin
         errors++; $display("FAIL load_stall: got %b expected 1", bus.stall_mem);
      end
      tick();
      checks++;
      if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h100 || bus.m_we !== 1'b0) begin
         errors++; $display("FAIL load_issue: got req=%b addr=%h we=%b expected 1/100/0", bus.m_req, bus.m_addr, bus.m_we);
      end
      tick();
      checks++;
      if (bus.m_req !== 1'b0 || bus.d_done !== 1'b0 || bus.stall_mem !== 1'b1) begin
         errors++; $display("FAIL load_wait: got req=%b done=%b stall=%b expected 0/0/1", bus.m_req, bus.d_done, bus.stall_mem);
      end
      bus.m_rvalid = 1; bus.m_rdata = 32'hDEADBEEF;
      tick();
      checks++;
      if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'hDEADBEEF || bus.i_done !== 1'b0) begin
         errors++; $display("FAIL load_done: got done=%b rdata=%h expected 1/deadbeef", bus.d_done, bus.d_rdata);
      end
      checks++;
      if (bus.stall_mem !== 1'b0) begin
         errors++; $display("FAIL load_stall_release: got %b expected 0", bus.stall_mem);
      end
      bus.d_req = 0; bus.m_rvalid = 0;
      tick();
      checks++;
      if (bus.d_done !== 1'b0 || bus.m_req !== 1'b0) begin
         errors++; $display("FAIL load_single_pulse: got done=%b req=%b expected 0/0", bus.d_done, bus.m_req);
      end
   endtask

   task automatic test_store();
      bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h200; bus.d_wdata = 32'h12345678;
      bus.m_ready = 1; bus.m_rvalid = 0;
      tick();
      checks++;
      if (bus.m_req !== 1'b1 || bus.m_we !== 1'b1 || bus.m_addr !== 32'h200 || bus.m_wdata !== 32'h12345678) begin
         errors++; $display("FAIL store_issue: got req=%b we=%b addr=%h wdata=%h expected 1/1/200/12345678",
                            bus.m_req, bus.m_we, bus.m_addr, bus.m_wdata);
      end
      tick();
      bus.m_rvalid = 1; bus.m_rdata = 32'hAAAA5555;
      tick();
      checks++;
      if (bus.d_done !== 1'b1 || bus.d_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL store_done: got done=%b rdata=%h expected 1/deadbeef", bus.d_done, bus.d_rdata);
      end
      bus.d_req = 0; bus.d_we = 0; bus.m_rvalid = 0;
      tick();
   endtask

   task automatic test_backpressure();
      bus.i_req = 1; bus.i_addr = 32'h400; bus.m_ready = 0; bus.m_rvalid = 0;
      tick();
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (bus.m_req !== 1'b1 || bus.m_addr !== 32'h400 || bus.m_we !== 1'b0 || bus.i_done !== 1'b0 || bus.stall_if !== 1'b1) begin
            errors++; $display("FAIL bp_hold[%0d]: got req=%b addr=%h we=%b done=%b stall=%b expected 1/400/0/0/1",
                               c, bus.m_req, bus.m_addr, bus.m_we, bus.i_done, bus.stall_if);
         end
         tick();
      end
      bus.m_ready = 1;
      tick();
      checks++;
      if (bus.m_req !== 1'b0 || bus.i_done !== 1'b0) begin
         errors++; $display("FAIL bp_accept: got req=%b done=%b expected 0/0", bus.m_req, bus.i_done);
      end
      bus.m_rvalid = 1; bus.m_rdata = 32'hCAFEF00D;
      tick();
      checks++;
      if (bus.i_done !== 1'b1 || bus.i_rdata !== 32'hCAFEF00D || bus.d_done !== 1'b0 || bus.d_rdata !== 32'hDEADBEEF) begin
         errors++; $display("FAIL bp_fetch_done: got idone=%b irdata=%h ddone=%b drdata=%h expected 1/cafef00d/0/deadbeef",
                            bus.i_done, bus.i_rdata, bus.d_done, bus.d_rdata);
      end
      bus.i_req = 0; bus.m_rvalid = 0;
      tick();
   endtask

   task automatic test_contention();
      string seq = "";
      int    n = 0;
      bit    both = 0;
      logic [2:0] cnt_at_4th_d = 3'd7;
      logic [2:0] cnt_at_i = 3'd7;
      rst = 1; tick(); rst = 0;
      bus.i_req = 1; bus.i_addr = 32'h40; bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h80;
      bus.m_ready = 1; bus.m_rvalid = 1; bus.m_rdata = 32'h5A5A5A5A;
      for (int c = 0; c < 200 && n < 10; c++) begin
         tick();
         if (bus.i_done && bus.d_done) both = 1;
         if (bus.d_done) begin
            seq = {seq, "D"}; n++;
            if (n == 4) cnt_at_4th_d = dut.starve_cnt;
         end else if (bus.i_done) begin
            seq = {seq, "I"}; n++;
            if (n == 5) cnt_at_i = dut.starve_cnt;
         end
      end
      bus.i_req = 0; bus.d_req = 0; bus.m_rvalid = 0;
      checks++;
      if (n != 10) begin
         errors++; $display("FAIL cont_timeout: got %0d grants expected 10", n);
      end
      checks++;
      if (seq != "DDDDIDDDDI") begin
         errors++; $display("FAIL cont_order: got %s expected DDDDIDDDDI", seq);
      end
      checks++;
      if (both) begin
         errors++; $display("FAIL cont_exclusive: got both dones expected never");
      end
      checks++;
      if (cnt_at_4th_d !== 3'd4 || cnt_at_i !== 3'd0) begin
         errors++; $display("FAIL cont_starve: got %0d/%0d expected 4/0", cnt_at_4th_d, cnt_at_i);
      end
`ifdef ARB_PERF_CNT_EN
      checks++;
      if (perf_d_grants !== 32'd8 || perf_i_grants !== 32'd2 || perf_starve_forced !== 32'd2) begin
         errors++; $display("FAIL perf_counts: got d=%0d i=%0d forced=%0d expected 8/2/2",
                            perf_d_grants, perf_i_grants, perf_starve_forced);
      end
`endif
      tick(); tick();
   endtask

   task automatic test_reset_in_wait();
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = 32'h300; bus.m_ready = 1; bus.m_rvalid = 0;
      tick(); tick();
      checks++;
      if (bus.m_req !== 1'b0 || bus.m_addr !== 32'h300) begin
         errors++; $display("FAIL rw_wait: got req=%b addr=%h expected 0/300", bus.m_req, bus.m_addr);
      end
      rst = 1;
      tick();
      rst = 0; bus.d_req = 0; bus.m_rvalid = 1; bus.m_rdata = 32'h0BADF00D;
      tick();
      checks++;
      if (bus.d_done !== 1'b0 || bus.i_done !== 1'b0 || bus.m_req !== 1'b0) begin
         errors++; $display("FAIL rw_no_done: got ddone=%b idone=%b req=%b expected 0/0/0", bus.d_done, bus.i_done, bus.m_req);
      end
      checks++;
      if (bus.m_addr !== 32'h0 || bus.d_rdata !== 32'h0 || bus.i_rdata !== 32'h0 || bus.m_we !== 1'b0) begin
         errors++; $display("FAIL rw_outputs: got addr=%h drdata=%h irdata=%h we=%b expected 0",
                            bus.m_addr, bus.d_rdata, bus.i_rdata, bus.m_we);
      end
      checks++;
      if (dut.state != 2'd0) begin
         errors++; $display("FAIL rw_state: got %0d expected 0 (IDLE)", dut.state);
      end
      bus.m_rvalid = 0;
      tick();
      checks++;
      if (bus.d_done !== 1'b0 || bus.m_req !== 1'b0) begin
         errors++; $display("FAIL rw_idle: got ddone=%b req=%b expected 0/0", bus.d_done, bus.m_req);
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_backpressure();
      test_contention();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
